inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, PC width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port push_valid_ifq_p1  input  1  fetch offers an entry.
REQ-007 SHALL have port push_inst_ifq_p1  input  DATA_W  instruction offered.
REQ-008 SHALL have port push_pc_ifq_p1  input  ADDR_W  PC of the offered instruction.
REQ-009 SHALL have port push_ready_ifq_p1  output  1  queue accepts the offered entry this cycle.
REQ-010 SHALL have port pop_valid_qid_p1  output  1  head entry is valid for decode.
REQ-011 SHALL have port pop_inst_qid_p1  output  DATA_W  head instruction.
REQ-012 SHALL have port pop_pc_qid_p1  output  ADDR_W  head PC.
REQ-013 SHALL have port pop_ready_qid_p1  input  1  decode consumes the head this cycle.
REQ-014 SHALL have port flush_p1  input  1  jump, branch or exception redirect; discard all entries.
REQ-015 SHALL have port halt_p1  input  1  halt decoded; stop intake and drain.
REQ-016 SHALL have port count_p1  output  clog2(DEPTH+1)  current occupancy.
REQ-017 SHALL have port halted_p1  output  1  queue is in HALTED.
REQ-018 SHALL have port err_p1  output  1  sticky error flag.

Function
REQ-019 Push handshake SHALL be push_valid_ifq_p1 AND push_ready_ifq_p1; pop handshake SHALL be pop_valid_qid_p1 AND pop_ready_qid_p1.
REQ-020 push_ready_ifq_p1 SHALL equal (count_p1 < DEPTH) AND state==RUN AND NOT flush_p1; it SHALL be combinational from state only, never from push_valid.
REQ-021 At full, push_ready_ifq_p1 SHALL be 0 even if a pop occurs in the same cycle.
REQ-022 Latency SHALL be 1 cycle: an entry pushed in cycle N is presented on the pop outputs no earlier than N+1; there is no empty bypass.
REQ-023 pop_valid_qid_p1 SHALL equal (count_p1 != 0); pop_inst_qid_p1 and pop_pc_qid_p1 SHALL be the head entry when valid and all-zero when not valid.
REQ-024 Entries SHALL leave in push order; read and write pointers SHALL each be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-025 Simultaneous push and pop on a non-empty queue SHALL leave count_p1 unchanged and advance both pointers.
REQ-026 A pop while empty SHALL be ignored, with no pointer or count change.
REQ-027 flush_p1 SHALL, on the next edge, set both pointers and count_p1 to 0; a push or pop in the flush cycle SHALL have no effect; flush SHALL take priority over every other event.
REQ-028 The state machine SHALL have the states RUN, DRAIN and HALTED.
REQ-029 RUN SHALL go to DRAIN on halt_p1=1; if the queue is already empty, or becomes empty in that cycle, it SHALL go directly to HALTED.
REQ-030 DRAIN SHALL go to HALTED when the final pop empties the queue, or on flush_p1.
REQ-031 HALTED SHALL be exited only by rst; halted_p1 SHALL be 1 only in HALTED.
REQ-032 halt_p1 and flush_p1 asserted together in RUN SHALL give HALTED with count_p1=0 on the next edge.
REQ-033 err_p1 SHALL be set when push_valid_ifq_p1=1 while in HALTED, and SHALL remain set until rst.

Reset
REQ-034 On rst, on the clock edge, the block SHALL set: state RUN, both pointers 0, count_p1 0, err_p1 0, halted_p1 0, pop_valid_qid_p1 0, push_ready_ifq_p1 1.
REQ-035 Storage array contents SHALL NOT be reset; stale data SHALL never be visible because of the output gating in REQ-023.
REQ-036 rst mid-drain or mid-flush SHALL override every other input in that cycle.

Structure
REQ-037 The queue state enum (RUN, DRAIN, HALTED) and the NOP encoding constant SHALL live in the shared urisc_pkg package.
REQ-038 The storage array SHALL be one sub-module, inst_queue_mem: DEPTH x (DATA_W+ADDR_W) entries, one synchronous write port and one combinational read port.
REQ-039 Pointer, count and FSM logic SHALL reside in inst_queue.

Verification
REQ-040 Fill then drain: push 4 entries (0x1111/0x0000 .. 0x4444/0x0006) with pop_ready=0 -> count_p1=4, push_ready=0; then set pop_ready=1 -> pops occur in push order over 4 cycles.
REQ-041 Wrap-around: run 10 continuous push+pop cycles at count 2 -> count_p1 stays 2 and no entry is lost or duplicated across the pointer wrap.
REQ-042 Flush: with count 3, assert flush_p1 together with a push -> next cycle count_p1=0 and pop_valid=0; the pushed entry never appears.
REQ-043 Halt drain: with count 2, pulse halt_p1 -> push_ready=0, 2 pops complete, then halted_p1=1; a push_valid afterwards sets err_p1=1.
REQ-044 Simultaneous halt+flush with count 3 -> next cycle halted_p1=1 and count_p1=0.
REQ-045 Reset in DRAIN with count 1 -> next cycle state RUN, count_p1=0, err_p1=0, push_ready=1.

Source files
------------

// File: rtl/urisc_pkg.sv
// Shared definitions for the micro-RISC front end: instruction-queue state
// encoding and the NOP instruction word.
package urisc_pkg;

  typedef enum logic [1:0] {
    IQ_RUN    = 2'd0,
    IQ_DRAIN  = 2'd1,
    IQ_HALTED = 2'd2
  } iq_state_e;

  localparam logic [15:0] NOP_INST = 16'h0000;

endpackage

// File: rtl/inst_queue_mem.sv
// Instruction queue storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset; the owner gates the read data.
module inst_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO with flush and halt/drain control.
// Pointers, occupancy and the RUN/DRAIN/HALTED machine live here; storage is in inst_queue_mem.
module inst_queue
  import urisc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid_ifq_p1,
  input  logic [DATA_W-1:0]          push_inst_ifq_p1,
  input  logic [ADDR_W-1:0]          push_pc_ifq_p1,
  output logic                       push_ready_ifq_p1,
  output logic                       pop_valid_qid_p1,
  output logic [DATA_W-1:0]          pop_inst_qid_p1,
  output logic [ADDR_W-1:0]          pop_pc_qid_p1,
  input  logic                       pop_ready_qid_p1,
  input  logic                       flush_p1,
  input  logic                       halt_p1,
  output logic [$clog2(DEPTH+1)-1:0] count_p1,
  output logic                       halted_p1,
  output logic                       err_p1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = DATA_W + ADDR_W;

  iq_state_e         state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic              push_fire, pop_fire;
  logic [EW-1:0]     rd_entry;

  // Ready depends only on registered state (and flush), never on push_valid,
  // so a full queue refuses pushes even when decode pops in the same cycle.
  assign push_ready_ifq_p1 = (count_q < CW'(DEPTH)) && (state_q == IQ_RUN) && !flush_p1;
  assign pop_valid_qid_p1  = (count_q != '0);
  assign push_fire         = push_valid_ifq_p1 && push_ready_ifq_p1;
  assign pop_fire          = pop_valid_qid_p1 && pop_ready_qid_p1;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | (push_valid_ifq_p1 && (state_q == IQ_HALTED));
    if (flush_p1) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if ((state_q == IQ_DRAIN) || ((state_q == IQ_RUN) && halt_p1)) state_d = IQ_HALTED;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
      // Halt looks at the post-update occupancy so an emptying pop goes straight to HALTED.
      case (state_q)
        IQ_RUN:   if (halt_p1) state_d = (count_d == '0) ? IQ_HALTED : IQ_DRAIN;
        IQ_DRAIN: if (count_d == '0) state_d = IQ_HALTED;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IQ_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  inst_queue_mem #(.DEPTH(DEPTH), .WIDTH(EW), .AW(PW)) u_mem (
    .clk   (clk),
    .we    (push_fire),
    .waddr (wr_ptr_q),
    .wdata ({push_inst_ifq_p1, push_pc_ifq_p1}),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign pop_inst_qid_p1 = pop_valid_qid_p1 ? rd_entry[EW-1:ADDR_W] : '0;
  assign pop_pc_qid_p1   = pop_valid_qid_p1 ? rd_entry[ADDR_W-1:0]  : '0;
  assign count_p1        = count_q;
  assign halted_p1       = (state_q == IQ_HALTED);
  assign err_p1          = err_q;

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_inst_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pv = 1'b0, pr = 1'b0, flush = 1'b0, halt = 1'b0;
  logic [15:0] pinst = '0, ppc = '0;
  logic        push_ready, pop_valid, halted, err;
  logic [15:0] pop_inst, pop_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  // reference model: mq holds {inst,pc}; mst 0=run 1=drain 2=halted
  logic [31:0] mq[$];
  int          mst = 0;
  bit          merr = 1'b0;

  always #5 clk = ~clk;

  inst_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .push_valid_ifq_p1 (pv),
    .push_inst_ifq_p1  (pinst),
    .push_pc_ifq_p1    (ppc),
    .push_ready_ifq_p1 (push_ready),
    .pop_valid_qid_p1  (pop_valid),
    .pop_inst_qid_p1   (pop_inst),
    .pop_pc_qid_p1     (pop_pc),
    .pop_ready_qid_p1  (pr),
    .flush_p1          (flush),
    .halt_p1           (halt),
    .count_p1          (count),
    .halted_p1         (halted),
    .err_p1            (err)
  );

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit rdy, vld;
    rdy = (mq.size() < DEPTH) && (mst == 0) && !flush;
    vld = (mq.size() != 0);
    if (rst) begin
      mq.delete(); mst = 0; merr = 1'b0;
    end else begin
      if (pv && mst == 2) merr = 1'b1;
      if (flush) begin
        mq.delete();
        if (mst == 1 || (mst == 0 && halt)) mst = 2;
      end else begin
        if (vld && pr) void'(mq.pop_front());
        if (pv && rdy) mq.push_back({pinst, ppc});
        if (mst == 0 && halt) mst = (mq.size() == 0) ? 2 : 1;
        else if (mst == 1 && mq.size() == 0) mst = 2;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst = 0; pv = 0; pr = 0; flush = 0; halt = 0; pinst = '0; ppc = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic push_one(input logic [15:0] i, input logic [15:0] p);
    pv = 1; pinst = i; ppc = p; pr = 0; tick(); pv = 0;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (pop_valid !== 1'b0 || pop_inst !== 16'h0 || pop_pc !== 16'h0) begin errors++; $display("FAIL reset_pop got v%b %h/%h exp 0", pop_valid, pop_inst, pop_pc); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", push_ready); end
    checks++; if (halted !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags got h%b e%b exp 0 0", halted, err); end
  endtask

  task automatic test_fill_drain();
    logic [15:0] ei [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] ep [4] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
    do_reset();
    push_one(ei[0], ep[0]);
    #1;
    checks++; if (pop_valid !== 1'b1 || pop_inst !== 16'h1111) begin errors++; $display("FAIL fill_latency got v%b %h exp 1 1111", pop_valid, pop_inst); end
    for (int i = 1; i < 4; i++) push_one(ei[i], ep[i]);
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", push_ready); end
    // full queue must refuse a push even with a concurrent pop
    pv = 1; pinst = 16'hBEEF; ppc = 16'h00EE; pr = 1; #1;
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %b exp 0", push_ready); end
    pv = 0; pr = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (pop_valid !== 1'b1 || pop_inst !== ei[i] || pop_pc !== ep[i]) begin
        errors++; $display("FAIL drain_order[%0d] got v%b %h/%h exp %h/%h", i, pop_valid, pop_inst, pop_pc, ei[i], ep[i]);
      end
      tick();
    end
    #1;
    checks++; if (count !== 3'd0 || pop_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got c%0d v%b exp 0 0", count, pop_valid); end
    idle();
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    do_reset();
    push_one(16'hA000, 16'h0100);
    push_one(16'hA001, 16'h0102);
    for (int i = 0; i < 10; i++) begin
      pv = 1; pr = 1; pinst = 16'($urandom); ppc = 16'($urandom); #1;
      exp = mq[0];
      checks++; if ({pop_inst, pop_pc} !== exp || count !== 3'd2) begin
        errors++; $display("FAIL wrap[%0d] got c%0d %h/%h exp c2 %h/%h", i, count, pop_inst, pop_pc, exp[31:16], exp[15:0]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) push_one(16'h5000 + 16'(i), 16'(i*2));
    flush = 1; pv = 1; pinst = 16'hDEAD; ppc = 16'h0DEA; pr = 1; tick(); idle();
    #1;
    checks++; if (count !== 3'd0 || pop_valid !== 1'b0) begin errors++; $display("FAIL flush got c%0d v%b exp 0 0", count, pop_valid); end
    tick(); tick(); #1;
    checks++; if (pop_valid !== 1'b0 || pop_inst !== 16'h0) begin errors++; $display("FAIL flush_ghost got v%b %h exp 0 0000", pop_valid, pop_inst); end
    checks++; if (push_ready !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL flush_run got r%b h%b exp 1 0", push_ready, halted); end
  endtask

  task automatic test_halt_drain();
    do_reset();
    push_one(16'h6001, 16'h0010);
    push_one(16'h6002, 16'h0012);
    halt = 1; tick(); halt = 0; #1;
    checks++; if (push_ready !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL drain_enter got r%b h%b exp 0 0", push_ready, halted); end
    pr = 1; #1;
    checks++; if (pop_inst !== 16'h6001) begin errors++; $display("FAIL drain_pop0 got %h exp 6001", pop_inst); end
    tick(); #1;
    checks++; if (pop_inst !== 16'h6002 || halted !== 1'b0) begin errors++; $display("FAIL drain_pop1 got %h h%b exp 6002 0", pop_inst, halted); end
    tick(); pr = 0; #1;
    checks++; if (halted !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL drain_halted got h%b c%0d exp 1 0", halted, count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL drain_err_pre got %b exp 0", err); end
    pv = 1; tick(); pv = 0; tick(); #1;
    checks++; if (err !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL halted_err got e%b c%0d exp 1 0", err, count); end
  endtask

  task automatic test_halt_flush();
    do_reset();
    for (int i = 0; i < 3; i++) push_one(16'h7000 + 16'(i), 16'(i));
    halt = 1; flush = 1; tick(); idle(); #1;
    checks++; if (halted !== 1'b1 || count !== 3'd0 || pop_valid !== 1'b0) begin errors++; $display("FAIL halt_flush got h%b c%0d v%b exp 1 0 0", halted, count, pop_valid); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    push_one(16'h8001, 16'h0020);
    push_one(16'h8002, 16'h0022);
    halt = 1; tick(); halt = 0;
    pr = 1; tick(); pr = 0; #1;
    checks++; if (count !== 3'd1 || halted !== 1'b0) begin errors++; $display("FAIL pre_rst got c%0d h%b exp 1 0", count, halted); end
    rst = 1; pr = 1; pv = 1; flush = 1; tick(); idle(); #1;
    checks++; if (count !== 3'd0 || err !== 1'b0 || push_ready !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("FAIL rst_drain got c%0d e%b r%b h%b exp 0 0 1 0", count, err, push_ready, halted);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    bit          ev, er;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      pv    = ($urandom_range(0, 9) < 6);
      pr    = ($urandom_range(0, 9) < 5);
      flush = ($urandom_range(0, 29) == 0);
      halt  = ($urandom_range(0, 39) == 0);
      rst   = (mst == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
      pinst = 16'($urandom); ppc = 16'($urandom);
      #1;
      ev  = (mq.size() != 0);
      er  = (mq.size() < DEPTH) && (mst == 0) && !flush;
      exp = ev ? mq[0] : 32'h0;
      checks++; if (count !== 3'(mq.size())) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", cyc, count, mq.size()); end
      checks++; if (pop_valid !== ev || {pop_inst, pop_pc} !== exp) begin
        errors++; $display("FAIL rand_pop cyc %0d got v%b %h/%h exp v%b %h/%h", cyc, pop_valid, pop_inst, pop_pc, ev, exp[31:16], exp[15:0]);
      end
      checks++; if (push_ready !== er) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, push_ready, er); end
      checks++; if (halted !== (mst == 2) || err !== merr) begin
        errors++; $display("FAIL rand_flags cyc %0d got h%b e%b exp h%b e%b", cyc, halted, err, (mst == 2), merr);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flush();
    test_halt_drain();
    test_halt_flush();
    test_reset_in_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
